// File: rtl/dmem_pkg.sv
// Shared types, widths and helpers for the data-memory bridge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } dmem_state_t;

   localparam int DMEM_ADDR_W = 64;
   localparam int DMEM_DATA_W = 64;
   localparam int DMEM_STRB_W = DMEM_DATA_W / 8;

   // A byte lane is written if any bit of its mask byte is set.
   function automatic logic [DMEM_STRB_W-1:0] mask_to_strb(input logic [DMEM_DATA_W-1:0] mask);
      logic [DMEM_STRB_W-1:0] strb;
      strb = '0;
      for (int i = 0; i < DMEM_STRB_W; i++) begin
         strb[i] = |mask[8*i +: 8];
      end
      return strb;
   endfunction

endpackage

// File: rtl/dmem_bridge.sv
// Bridges the core's single-cycle RAM port onto a valid/ready memory bus.
// Latency: 3 cycles (IDLE, REQ, WAIT) on a zero-wait bus, 5 for a write+read pair; DONE follows.
// Backpressure: stall held while an access is outstanding; req fields hold until req_ready.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   RamRead*/RamWrite*            core memory-stage request (write wins ordering if both)
//   RamReadData, stall, err       registered read data, pipeline freeze, timeout pulse
//   req_*                         bus request channel (registered outputs)
//   resp_valid/resp_rdata         bus response; resp_ready high only while waiting
module dmem_bridge
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = DMEM_ADDR_W,
   parameter int DATA_W  = DMEM_DATA_W,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   // core side
   input  logic                RamReadEnable,
   input  logic [ADDR_W-1:0]   RamReadAddr,
   input  logic                RamWriteEnable,
   input  logic [ADDR_W-1:0]   RamWriteAddr,
   input  logic [DATA_W-1:0]   RamWriteData,
   input  logic [DATA_W-1:0]   RamWriteMask,
   output logic [DATA_W-1:0]   RamReadData,
   output logic                stall,
   output logic                err,
   // bus side
   output logic                req_valid,
   input  logic                req_ready,
   output logic                req_write,
   output logic [ADDR_W-1:0]   req_addr,
   output logic [DATA_W-1:0]   req_wdata,
   output logic [DATA_W/8-1:0] req_wstrb,
   input  logic                resp_valid,
   input  logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_ready
);

   localparam int STRB_W = DATA_W / 8;
   localparam int TCNT_W = $clog2(TIMEOUT + 1);

   dmem_state_t       r_state;
   logic              r_req_valid;
   logic              r_resp_ready;
   logic              r_req_write;
   logic [ADDR_W-1:0] r_req_addr;
   logic [DATA_W-1:0] r_req_wdata;
   logic [STRB_W-1:0] r_req_wstrb;
   logic              r_rd_pending;
   logic [ADDR_W-1:0] r_rd_addr;     // read address parked while the write goes first
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;
   logic [TCNT_W-1:0] r_tcnt;

   logic [STRB_W-1:0] w_strb;
   logic [TCNT_W-1:0] w_tcnt_inc;

   // Mask conversion is sized by the package data width; DATA_W tracks it.
   assign w_strb = mask_to_strb(RamWriteMask);

   // Saturating increment so a stuck counter can never wrap back below TIMEOUT.
   always_comb begin
      w_tcnt_inc = r_tcnt;
      if (r_tcnt != TCNT_W'(TIMEOUT)) begin
         w_tcnt_inc = r_tcnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_req_valid  <= 1'b0;
         r_resp_ready <= 1'b0;
         r_req_write  <= 1'b0;
         r_req_addr   <= '0;
         r_req_wdata  <= '0;
         r_req_wstrb  <= '0;
         r_rd_pending <= 1'b0;
         r_rd_addr    <= '0;
         r_rdata      <= '0;
         r_err        <= 1'b0;
         r_tcnt       <= '0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (RamWriteEnable) begin
                  r_req_write  <= 1'b1;
                  r_req_addr   <= RamWriteAddr;
                  r_req_wdata  <= RamWriteData;
                  r_req_wstrb  <= w_strb;
                  r_rd_pending <= RamReadEnable;
                  r_rd_addr    <= RamReadAddr;
                  r_req_valid  <= 1'b1;
                  r_state      <= REQ;
               end else if (RamReadEnable) begin
                  r_req_write  <= 1'b0;
                  r_req_addr   <= RamReadAddr;
                  r_req_wdata  <= '0;
                  r_req_wstrb  <= '0;
                  r_rd_pending <= 1'b0;
                  r_req_valid  <= 1'b1;
                  r_state      <= REQ;
               end
            end
            REQ: begin
               if (req_ready) begin
                  r_req_valid  <= 1'b0;
                  r_resp_ready <= 1'b1;
                  r_tcnt       <= '0;
                  r_state      <= WAIT;
               end
            end
            WAIT: begin
               if (resp_valid) begin
                  if (!r_req_write) begin
                     r_rdata <= resp_rdata;
                  end
                  r_resp_ready <= 1'b0;
                  if (r_rd_pending) begin
                     // Write acked: issue the parked read without returning to IDLE.
                     r_rd_pending <= 1'b0;
                     r_req_write  <= 1'b0;
                     r_req_addr   <= r_rd_addr;
                     r_req_wdata  <= '0;
                     r_req_wstrb  <= '0;
                     r_req_valid  <= 1'b1;
                     r_state      <= REQ;
                  end else begin
                     r_state <= DONE;
                  end
               end else begin
                  r_tcnt <= w_tcnt_inc;
                  if (w_tcnt_inc == TCNT_W'(TIMEOUT)) begin
                     r_err <= 1'b1;
                     if (!r_req_write) begin
                        r_rdata <= '0;
                     end
                     r_rd_pending <= 1'b0;
                     r_resp_ready <= 1'b0;
                     r_state      <= DONE;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // The core advances only in DONE; the following IDLE sees the next instruction.
   assign stall       = (RamReadEnable | RamWriteEnable) & (r_state != DONE);
   assign err         = r_err;
   assign RamReadData = r_rdata;
   assign req_valid   = r_req_valid;
   assign req_write   = r_req_write;
   assign req_addr    = r_req_addr;
   assign req_wdata   = r_req_wdata;
   assign req_wstrb   = r_req_wstrb;
   assign resp_ready  = r_resp_ready;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: a bus model checks each accepted request
// against a queue of expected requests; the core driver checks stall length,
// err pulses and read data against expectations queued at stimulus time.
module tb_dmem_bridge;

   typedef struct packed {
      logic        wr;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  strb;
   } req_t;

   logic        clk;
   logic        rst;
   logic        RamReadEnable;
   logic [63:0] RamReadAddr;
   logic        RamWriteEnable;
   logic [63:0] RamWriteAddr;
   logic [63:0] RamWriteData;
   logic [63:0] RamWriteMask;
   logic [63:0] RamReadData;
   logic        stall;
   logic        err;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_ready;

   dmem_bridge #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(8)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .RamReadEnable (RamReadEnable),
      .RamReadAddr   (RamReadAddr),
      .RamWriteEnable(RamWriteEnable),
      .RamWriteAddr  (RamWriteAddr),
      .RamWriteData  (RamWriteData),
      .RamWriteMask  (RamWriteMask),
      .RamReadData   (RamReadData),
      .stall         (stall),
      .err           (err),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_write     (req_write),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_wstrb     (req_wstrb),
      .resp_valid    (resp_valid),
      .resp_rdata    (resp_rdata),
      .resp_ready    (resp_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   req_t        exp_req_q[$];
   logic [63:0] exp_rd_q[$];

   int          g_rdy_delay = 0;
   bit          g_no_resp   = 1'b0;
   logic [63:0] g_rdata     = 64'h0;
   bit          last_rd     = 1'b0;
   int          rdy_cnt     = 0;
   int          err_seen    = 0;
   req_t        held;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] m2s(input logic [63:0] m);
      logic [7:0] s;
      for (int b = 0; b < 8; b++) begin
         s[b] = (m[8*b +: 8] != 8'h00);
      end
      return s;
   endfunction

   // Bus model: samples DUT outputs on the falling edge, drives ready/response for the next rising edge.
   always @(negedge clk) begin
      req_t e;
      err_seen += int'(err);
      if (req_valid) begin
         if (rdy_cnt == 0) begin
            held.wr    = req_write;
            held.addr  = req_addr;
            held.wdata = req_wdata;
            held.strb  = req_wstrb;
         end else begin
            chk("req_hold_addr",  req_addr,  held.addr);
            chk("req_hold_write", 64'(req_write), 64'(held.wr));
            chk("req_hold_wdata", req_wdata, held.wdata);
         end
         if (rdy_cnt < g_rdy_delay) begin
            req_ready = 1'b0;
         end else begin
            req_ready = 1'b1;
            if (exp_req_q.size() == 0) begin
               chk("unexpected_req", 64'd1, 64'd0);
            end else begin
               e = exp_req_q.pop_front();
               chk("req_write", 64'(req_write), 64'(e.wr));
               chk("req_addr",  req_addr,  e.addr);
               chk("req_wdata", req_wdata, e.wdata);
               chk("req_wstrb", 64'(req_wstrb), 64'(e.strb));
            end
            last_rd = !req_write;
         end
         rdy_cnt++;
      end else begin
         req_ready = 1'b0;
         rdy_cnt   = 0;
      end
      if (resp_ready && !g_no_resp) begin
         resp_valid = 1'b1;
         resp_rdata = last_rd ? g_rdata : 64'h0;
      end else begin
         resp_valid = 1'b0;
         resp_rdata = 64'h0;
      end
   end

   // One core access: exp_stall < 0 skips the stall-length check.
   task automatic access(input string tag, input bit we, input logic [63:0] wa, input logic [63:0] wd,
                         input logic [63:0] wm, input bit re, input logic [63:0] ra,
                         input logic [63:0] rd_exp, input int exp_stall, input int exp_err);
      req_t e;
      int   cyc;
      int   e0;
      cyc = 0;
      if (we) begin
         e.wr = 1'b1; e.addr = wa; e.wdata = wd; e.strb = m2s(wm);
         exp_req_q.push_back(e);
      end
      if (re) begin
         e.wr = 1'b0; e.addr = ra; e.wdata = 64'h0; e.strb = 8'h00;
         exp_req_q.push_back(e);
         exp_rd_q.push_back(rd_exp);
      end
      @(negedge clk); #1;
      e0 = err_seen;
      RamWriteEnable = we; RamWriteAddr = wa; RamWriteData = wd; RamWriteMask = wm;
      RamReadEnable  = re; RamReadAddr  = ra;
      #1;
      while (stall && cyc < 500) begin
         cyc++;
         @(negedge clk); #1;
      end
      if (stall) chk({tag, "_hang"}, 64'd1, 64'd0);
      if (exp_stall >= 0) chk({tag, "_stall"}, 64'(cyc), 64'(exp_stall));
      chk({tag, "_err"}, 64'(err_seen - e0), 64'(exp_err));
      if (re && exp_rd_q.size() != 0) chk({tag, "_rdata"}, RamReadData, exp_rd_q.pop_front());
      RamWriteEnable = 1'b0;
      RamReadEnable  = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no_finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      e_init: begin end
      rst = 1'b1;
      RamReadEnable = 1'b0; RamReadAddr = '0; RamWriteEnable = 1'b0;
      RamWriteAddr = '0; RamWriteData = '0; RamWriteMask = '0;
      req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_req_valid",  64'(req_valid),  64'd0);
      chk("rst_resp_ready", 64'(resp_ready), 64'd0);
      chk("rst_err",        64'(err),        64'd0);
      chk("rst_rdata",      RamReadData,     64'd0);
      chk("rst_stall",      64'(stall),      64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Plain read on a zero-wait bus.
      g_rdata = 64'h1122334455667788;
      access("rd0", 1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 64'h8000_0010, 64'h1122334455667788, 3, 0);

      // Masked write: two middle bytes.
      access("wr0", 1'b1, 64'h8000_0020, 64'hAABB_CCDD_0000_0000, 64'h0000_0000_FFFF_0000,
             1'b0, 64'h0, 64'h0, 3, 0);

      // Bus holds req_ready low for 4 cycles.
      g_rdy_delay = 4;
      g_rdata = 64'hDEAD_BEEF_CAFE_F00D;
      access("rdy4", 1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 64'h40, 64'hDEAD_BEEF_CAFE_F00D, 7, 0);
      g_rdy_delay = 0;

      // Write and read in the same instruction: write goes first, one DONE.
      g_rdata = 64'h0123_4567_89AB_CDEF;
      access("pair", 1'b1, 64'h100, 64'h5555_6666_7777_8888, 64'hFFFF_FFFF_FFFF_FFFF,
             1'b1, 64'h200, 64'h0123_4567_89AB_CDEF, 5, 0);

      // Reset while waiting for a response.
      g_no_resp = 1'b1;
      begin
         req_t e;
         e.wr = 1'b0; e.addr = 64'h300; e.wdata = 64'h0; e.strb = 8'h00;
         exp_req_q.push_back(e);
      end
      @(negedge clk); #1;
      RamReadEnable = 1'b1; RamReadAddr = 64'h300;
      w = 0;
      while (!resp_ready && w < 50) begin
         w++;
         @(negedge clk); #1;
      end
      chk("mid_reach_wait", 64'(resp_ready), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_req_valid",  64'(req_valid),  64'd0);
      chk("mid_rst_resp_ready", 64'(resp_ready), 64'd0);
      chk("mid_rst_rdata",      RamReadData,     64'd0);
      RamReadEnable = 1'b0;
      g_no_resp = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      g_rdata = 64'h0F0E_0D0C_0B0A_0908;
      access("rd_after_rst", 1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 64'h400, 64'h0F0E_0D0C_0B0A_0908, 3, 0);

      // No response at all: timeout aborts with err and zero data.
      g_no_resp = 1'b1;
      access("tmo", 1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 64'h500, 64'h0, -1, 1);
      g_no_resp = 1'b0;
      chk("tmo_idle_resp_ready", 64'(resp_ready), 64'd0);

      g_rdata = 64'h7777_0000_1111_2222;
      access("rd_after_tmo", 1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 64'h600, 64'h7777_0000_1111_2222, 3, 0);

      chk("req_q_empty", 64'(exp_req_q.size()), 64'd0);
      chk("err_idle", 64'(err), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
